// File: rtl/reg_file_banked.sv
// Dual-banked CPU register-pair file with byte-lane writes, a registered read port with write bypass,
// and the EXX / EX AF,AF' / EX DE,HL exchanges. Shadow banks are built only when REG_SHADOW_EN is defined.
module reg_file_banked #(
    parameter int unsigned        WIDTH     = 8,
    parameter int unsigned        NPAIRS    = 4,
    parameter logic [2*WIDTH-1:0] RESET_VAL = '1
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [$clog2(NPAIRS)-1:0] sel,
    input  logic                      we_hi,
    input  logic                      we_lo,
    input  logic [2*WIDTH-1:0]        wdata,
    input  logic                      rd_en,
    output logic [2*WIDTH-1:0]        rdata,
    output logic                      rd_valid,
    input  logic                      exx,
    input  logic                      ex_af,
    input  logic                      ex_de_hl,
    output logic                      bank_af,
    output logic                      bank_gp
);

    localparam int unsigned PW       = 2 * WIDTH;
    localparam int unsigned SELW     = $clog2(NPAIRS);
    localparam bit          HAS_DEHL = (NPAIRS >= 4);
`ifdef REG_SHADOW_EN
    localparam int unsigned NBANK    = 2;
`else
    localparam int unsigned NBANK    = 1;
`endif

    logic              af_bank;
    logic              gp_bank;
    logic [NBANK-1:0]  dehl_swap_q;
    logic [PW-1:0]     mem_q [NBANK][NPAIRS];
    logic [PW-1:0]     rdata_q, rdata_d;
    logic              rd_valid_q;
    logic              map_bank;
    logic [SELW-1:0]   map_pair;

`ifdef REG_SHADOW_EN
    logic af_bank_q, gp_bank_q;

    // Bank flags flip on the exchange strobes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            af_bank_q <= 1'b0;
            gp_bank_q <= 1'b0;
        end else begin
            af_bank_q <= af_bank_q ^ ex_af;
            gp_bank_q <= gp_bank_q ^ exx;
        end
    end

    assign af_bank = af_bank_q;
    assign gp_bank = gp_bank_q;
`else
    logic unused_ex;
    assign unused_ex = exx ^ ex_af;
    assign af_bank   = 1'b0;
    assign gp_bank   = 1'b0;
`endif

    // Logical select to physical bank/slot; DE and HL trade slots while the active bank's swap flag is set.
    always_comb begin
        map_bank = (sel == '0) ? af_bank : gp_bank;
        map_pair = sel;
        if (HAS_DEHL && dehl_swap_q[gp_bank] && (32'(sel) == 32'd2 || 32'(sel) == 32'd3)) begin
            map_pair = sel ^ SELW'(1);
        end
    end

    // Read capture with per-lane write-through.
    always_comb begin
        rdata_d = mem_q[map_bank][map_pair];
        if (we_hi) rdata_d[PW-1:WIDTH] = wdata[PW-1:WIDTH];
        if (we_lo) rdata_d[WIDTH-1:0]  = wdata[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int b = 0; b < int'(NBANK); b++) begin
                for (int p = 0; p < int'(NPAIRS); p++) begin
                    mem_q[b][p] <= RESET_VAL;
                end
            end
        end else begin
            if (we_hi) mem_q[map_bank][map_pair][PW-1:WIDTH] <= wdata[PW-1:WIDTH];
            if (we_lo) mem_q[map_bank][map_pair][WIDTH-1:0]  <= wdata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dehl_swap_q <= '0;
        end else if (HAS_DEHL && ex_de_hl) begin
            dehl_swap_q[gp_bank] <= ~dehl_swap_q[gp_bank];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rdata_q <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign bank_af  = af_bank;
    assign bank_gp  = gp_bank;

endmodule

// File: tb/tb_reg_file_banked.sv
// Scoreboard bench for reg_file_banked (WIDTH=8, NPAIRS=4); expectations follow REG_SHADOW_EN.
module tb_reg_file_banked;

`ifdef REG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  sel;
    logic        we_hi, we_lo, rd_en, exx, ex_af, ex_de_hl;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rd_valid, bank_af, bank_gp;

    int tests = 0;
    int fails = 0;
    int rd_id = 0;
    logic [15:0] exp_q[$];
    int          tag_q[$];

    reg_file_banked #(.WIDTH(8), .NPAIRS(4)) dut (
        .clk(clk), .nreset(nreset), .sel(sel), .we_hi(we_hi), .we_lo(we_lo),
        .wdata(wdata), .rd_en(rd_en), .rdata(rdata), .rd_valid(rd_valid),
        .exx(exx), .ex_af(ex_af), .ex_de_hl(ex_de_hl),
        .bank_af(bank_af), .bank_gp(bank_gp)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] s16(input logic [15:0] a, input logic [15:0] b);
        return SHADOW ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pops one expected word.
    always @(negedge clk) begin
        logic [15:0] e;
        int          id;
        if (rd_valid !== 1'b0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_valid_unexpected: got rd_valid=%b rdata=%h, required rd_valid=0", rd_valid, rdata);
            end else begin
                e  = exp_q.pop_front();
                id = tag_q.pop_front();
                if (rdata !== e) begin
                    fails++;
                    $display("FAIL read%0d: got rdata=%h, required %h", id, rdata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check();
        @(negedge clk);
        #1;
        check("read_latency", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wr(input logic [1:0] s, input logic [15:0] d, input logic hi, input logic lo);
        sel = s; wdata = d; we_hi = hi; we_lo = lo;
        tick();
        we_hi = 1'b0; we_lo = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [15:0] e);
        sel = s; rd_en = 1'b1;
        exp_q.push_back(e); tag_q.push_back(rd_id); rd_id++;
        tick();
        rd_en = 1'b0;
        drain_check();
    endtask

    task automatic pulse(input logic x, input logic a, input logic d);
        exx = x; ex_af = a; ex_de_hl = d;
        tick();
        exx = 1'b0; ex_af = 1'b0; ex_de_hl = 1'b0;
    endtask

    initial begin
        nreset = 1'b0; sel = '0; we_hi = 1'b0; we_lo = 1'b0; rd_en = 1'b0;
        exx = 1'b0; ex_af = 1'b0; ex_de_hl = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk); #1;
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_bank_af", 32'(bank_af), 32'd0);
        check("reset_bank_gp", 32'(bank_gp), 32'd0);

        // Back-to-back reads of every pair after reset.
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); rd_en = 1'b1;
            exp_q.push_back(16'hFFFF); tag_q.push_back(rd_id); rd_id++;
            tick();
        end
        rd_en = 1'b0;
        drain_check();

        // Byte lanes and bypass.
        wr(2'd1, 16'hAB56, 1'b1, 1'b0);
        rd(2'd1, 16'hABFF);
        wr(2'd1, 16'h1234, 1'b0, 1'b1);
        rd(2'd1, 16'hAB34);
        sel = 2'd3; wdata = 16'hAD58; we_hi = 1'b1; we_lo = 1'b1; rd_en = 1'b1;
        exp_q.push_back(16'hAD58); tag_q.push_back(rd_id); rd_id++;
        tick();
        we_hi = 1'b0; we_lo = 1'b0; rd_en = 1'b0;
        drain_check();
        sel = 2'd1; wdata = 16'h0077; we_lo = 1'b1; rd_en = 1'b1;
        exp_q.push_back(16'hAB77); tag_q.push_back(rd_id); rd_id++;
        tick();
        we_lo = 1'b0; rd_en = 1'b0;
        drain_check();
        rd(2'd1, 16'hAB77);

        // EXX and EX AF,AF'.
        wr(2'd0, 16'hAA55, 1'b1, 1'b1);
        wr(2'd1, 16'h1111, 1'b1, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        check("exx_bank_gp", 32'(bank_gp), 32'(SHADOW));
        check("exx_bank_af", 32'(bank_af), 32'd0);
        rd(2'd1, s16(16'hFFFF, 16'h1111));
        rd(2'd0, 16'hAA55);
        pulse(1'b0, 1'b1, 1'b0);
        check("exaf_bank_af", 32'(bank_af), 32'(SHADOW));
        rd(2'd0, s16(16'hFFFF, 16'hAA55));
        pulse(1'b1, 1'b1, 1'b0);
        check("back_bank_af", 32'(bank_af), 32'd0);
        check("back_bank_gp", 32'(bank_gp), 32'd0);
        rd(2'd0, 16'hAA55);
        rd(2'd1, 16'h1111);

        // EX DE,HL, including exx in the same cycle.
        wr(2'd2, 16'hAC57, 1'b1, 1'b1);
        wr(2'd3, 16'hAD58, 1'b1, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        rd(2'd2, 16'hAD58);
        rd(2'd3, 16'hAC57);
        pulse(1'b1, 1'b0, 1'b0);
        rd(2'd2, s16(16'hFFFF, 16'hAD58));
        rd(2'd3, s16(16'hFFFF, 16'hAC57));
        pulse(1'b1, 1'b0, 1'b0);
        rd(2'd2, 16'hAD58);
        rd(2'd3, 16'hAC57);
        pulse(1'b1, 1'b0, 1'b1);
        rd(2'd2, s16(16'hFFFF, 16'hAC57));
        pulse(1'b1, 1'b0, 1'b0);
        rd(2'd2, 16'hAC57);
        rd(2'd3, 16'hAD58);

        // Reset landing on a write+read cycle.
        pulse(1'b1, 1'b1, 1'b0);
        check("pre_reset_bank_gp", 32'(bank_gp), 32'(SHADOW));
        sel = 2'd2; wdata = 16'h1234; we_hi = 1'b1; we_lo = 1'b1; rd_en = 1'b1;
        @(negedge clk); #1;
        nreset = 1'b0;
        #1;
        check("async_rdata_clear", 32'(rdata), 32'd0);
        check("async_bank_gp", 32'(bank_gp), 32'd0);
        check("async_bank_af", 32'(bank_af), 32'd0);
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0; rd_en = 1'b0;
        nreset = 1'b1;
        @(negedge clk); #1;
        check("post_reset_rd_valid", 32'(rd_valid), 32'd0);
        rd(2'd2, 16'hFFFF);
        rd(2'd0, 16'hFFFF);
        rd(2'd3, 16'hFFFF);

        repeat (2) @(posedge clk);
        #1;
        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
